// File: rtl/pll_scan_reader_if.sv
// Register-bus side of the PLL scan-chain reader.
// This interface carries the start/busy handshake and the byte read port.
interface pll_scan_reader_if;
  logic       i_start;
  logic       i_cfg_busy;
  logic       i_select;
  logic [4:0] i_addr;
  logic [7:0] o_data_rd;
  logic       o_busy;
  logic       o_done;
  logic       o_valid;

  // Bus master (software side / testbench) drives requests and reads results.
  modport master (
    output i_start, i_cfg_busy, i_select, i_addr,
    input  o_data_rd, o_busy, o_done, o_valid
  );

  // The reader block consumes requests and returns status and data.
  modport slave (
    input  i_start, i_cfg_busy, i_select, i_addr,
    output o_data_rd, o_busy, o_done, o_valid
  );
endinterface

// File: rtl/pll_scan_reader.sv
// Non-destructive readback of the PLL reconfiguration scan chain.
// Each bit leaving scandataout is looped back into scandata, so after
// CHAIN_LEN enabled clocks the chain is back in its original state.
// The captured image is latched into a snapshot that the bus reads bytewise.
module pll_scan_reader #(
  parameter int CHAIN_LEN = 158,
  parameter int CNT_W     = 8
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  pll_scan_reader_if.slave    bus,
  output logic                o_scanclkena,
  output logic                o_scandata,
  input  logic                i_scandataout
);

  // The bus can address 32 bytes; anything past the chain reads as zero.
  localparam int NUM_BYTES = 32;
  localparam int PAD_W     = 8 * NUM_BYTES;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CHAIN_LEN-1:0]   r_cap;
  logic [CHAIN_LEN-1:0]   r_snap;
  logic                   r_valid;
  logic [7:0]             r_data_rd;
  logic                   w_start_ok;
  logic                   w_last;
  logic                   w_busy;
  logic                   w_done;
  logic                   w_scanclkena;
  logic                   w_scandata;
  logic [PAD_W-1:0]       w_pad;
  logic [7:0]             w_byte [NUM_BYTES];

  // A start request while the writer owns the chain is dropped, not queued.
  assign w_start_ok = bus.i_start & ~bus.i_cfg_busy;
  assign w_last     = (r_cnt == CNT_W'(CHAIN_LEN - 1));

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> SHIFT for CHAIN_LEN clocks -> DONE for one clock.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last)     w_state_next = S_DONE;
      S_DONE:                  w_state_next = S_IDLE;
      default:                 w_state_next = S_IDLE;
    endcase
  end

  // Output decode; scandata recirculates scandataout only while shifting.
  always_comb begin
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_scanclkena = 1'b0;
    w_scandata   = 1'b0;
    case (r_state)
      S_SHIFT: begin
        w_busy       = 1'b1;
        w_scanclkena = 1'b1;
        w_scandata   = i_scandataout;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Shift counter and capture register; first bit out lands in r_cap[0].
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
      r_cap <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_start_ok) begin
        r_cnt <= '0;
        r_cap <= '0;
      end
    end else if (r_state == S_SHIFT) begin
      r_cap <= {i_scandataout, r_cap[CHAIN_LEN-1:1]};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Snapshot only moves on DONE, so reads during a shift see the old image.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_snap  <= '0;
      r_valid <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_snap  <= r_cap;
      r_valid <= 1'b1;
    end
  end

  // Zero-pad the snapshot to the full addressable byte range.
  genvar gi;
  generate
    for (gi = 0; gi < PAD_W; gi++) begin : g_pad
      if (gi < CHAIN_LEN) begin : g_bit
        assign w_pad[gi] = r_snap[gi];
      end else begin : g_zero
        assign w_pad[gi] = 1'b0;
      end
    end
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
      assign w_byte[gi] = w_pad[8*gi +: 8];
    end
  endgenerate

  // Registered byte read; holds its value when not selected.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)        r_data_rd <= 8'h00;
    else if (bus.i_select) r_data_rd <= w_byte[bus.i_addr];
  end

  assign bus.o_data_rd = r_data_rd;
  assign bus.o_busy    = w_busy;
  assign bus.o_done    = w_done;
  assign bus.o_valid   = r_valid;
  assign o_scanclkena  = w_scanclkena;
  assign o_scandata    = w_scandata;

endmodule

// File: tb/tb_pll_scan_reader.sv
// Bench for pll_scan_reader: a PLL scan-chain model (shifts on each
// enabled clock, scandataout = chain[0]) plus table-driven and randomized
// reads checked against images predicted from the loaded chain contents.
module tb_pll_scan_reader;
  localparam int L = 158;

  logic          clk;
  logic          reset_n;
  logic          scanclkena;
  logic          scandata;
  logic          scandataout;
  logic [L-1:0]  chain;
  logic          load_en;
  logic [L-1:0]  load_val;
  int            vec_cnt;
  int            miscmp;

  pll_scan_reader_if bus();

  pll_scan_reader #(.CHAIN_LEN(L), .CNT_W(8)) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .bus           (bus),
    .o_scanclkena  (scanclkena),
    .o_scandata    (scandata),
    .i_scandataout (scandataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PLL scan chain: bit 0 leaves first, scandata enters at the top.
  assign scandataout = chain[0];
  always @(posedge clk) begin
    if (load_en)         chain <= load_val;
    else if (scanclkena) chain <= {scandata, chain[L-1:1]};
  end

  typedef struct {
    bit         sel;
    logic [4:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load_chain(input logic [L-1:0] v);
    load_val = v;
    load_en  = 1'b1;
    tick();
    load_en  = 1'b0;
  endtask

  task automatic read_byte(input logic [4:0] a, output logic [7:0] d);
    bus.i_select = 1'b1;
    bus.i_addr   = a;
    tick();
    bus.i_select = 1'b0;
    d = bus.o_data_rd;
  endtask

  // Image with byte k = k + base, truncated to the chain length.
  function automatic logic [L-1:0] byte_pattern(input logic [7:0] base, input bit xor_mode);
    logic [L-1:0] v;
    logic [7:0]   b;
    v = '0;
    for (int k = 0; k < 20; k++) begin
      b = xor_mode ? (base ^ 8'(k)) : (base + 8'(k));
      for (int j = 0; j < 8; j++)
        if (8*k + j < L) v[8*k + j] = b[j];
    end
    return v;
  endfunction

  // Reference byte of a snapshot image: bits past the chain end are zero.
  function automatic logic [7:0] ref_byte(input logic [L-1:0] img, input int a);
    logic [7:0] r;
    r = 8'h00;
    for (int j = 0; j < 8; j++)
      if (8*a + j < L) r[j] = img[8*a + j];
    return r;
  endfunction

  // Pulse start, then observe 200 cycles; optional extra start and a read.
  task automatic run(input bit busy_in, input int again_t, input int read_t,
                     input logic [4:0] raddr, output int en, output int nb,
                     output int done_t, output int n_done, output logic [7:0] rdata);
    bus.i_cfg_busy = busy_in;
    bus.i_start    = 1'b1;
    tick();
    bus.i_start    = 1'b0;
    bus.i_cfg_busy = 1'b0;
    en = 0; nb = 0; done_t = 0; n_done = 0; rdata = 8'h00;
    for (int t = 1; t <= 200; t++) begin
      if (scanclkena) en++;
      if (bus.o_busy) nb++;
      if (bus.o_done) begin
        n_done++;
        if (done_t == 0) done_t = t;
      end
      bus.i_start  = (t == again_t);
      bus.i_select = (t == read_t);
      bus.i_addr   = raddr;
      tick();
      if (t == read_t) rdata = bus.o_data_rd;
      bus.i_start  = 1'b0;
      bus.i_select = 1'b0;
    end
  endtask

  task automatic check_good_run(input int en, input int nb, input int done_t, input int n_done);
    check("enable_cycles", 256'(en), 256'(158));
    check("busy_cycles", 256'(nb), 256'(159));
    check("done_cycle", 256'(done_t), 256'(159));
    check("done_count", 256'(n_done), 256'(1));
    check("valid_after", 256'(bus.o_valid), 256'(1));
  endtask

  initial begin
    logic [L-1:0] orig;
    logic [L-1:0] exp_img;
    logic [L-1:0] rot;
    logic [7:0]   d;
    int           en, nb, done_t, n_done;
    bit           blocked;
    logic [4:0]   a;

    vec_cnt = 0;
    miscmp  = 0;
    reset_n = 1'b0;
    load_en = 1'b0;
    load_val = '0;
    bus.i_start = 1'b0;
    bus.i_cfg_busy = 1'b0;
    bus.i_select = 1'b0;
    bus.i_addr = 5'd0;

    tbl[0] = '{1'b1, 5'd5,  8'h15};
    tbl[1] = '{1'b1, 5'd19, 8'h23};
    tbl[2] = '{1'b1, 5'd0,  8'h10};
    tbl[3] = '{1'b0, 5'd7,  8'h10};
    tbl[4] = '{1'b1, 5'd12, 8'h1c};
    tbl[5] = '{1'b1, 5'd20, 8'h00};
    tbl[6] = '{1'b0, 5'd2,  8'h00};
    tbl[7] = '{1'b1, 5'd31, 8'h00};

    // 1. Reset state and an all-zero snapshot.
    load_chain('0);
    tick(); tick();
    reset_n = 1'b1;
    check("rst_valid", 256'(bus.o_valid), 256'(0));
    check("rst_scanclkena", 256'(scanclkena), 256'(0));
    check("rst_busy", 256'(bus.o_busy), 256'(0));
    check("rst_done", 256'(bus.o_done), 256'(0));
    check("rst_scandata", 256'(scandata), 256'(0));
    for (int i = 0; i < 32; i++) begin
      read_byte(5'(i), d);
      check("rst_read", 256'(d), 256'(0));
    end

    // 2. Readback of a known pattern, then table-driven reads.
    orig = byte_pattern(8'h10, 1'b0);
    load_chain(orig);
    run(1'b0, 0, 0, 5'd0, en, nb, done_t, n_done, d);
    check_good_run(en, nb, done_t, n_done);
    check("chain_restored", 256'(chain), 256'(orig));
    for (int i = 0; i < 8; i++) begin
      bus.i_select = tbl[i].sel;
      bus.i_addr   = tbl[i].addr;
      tick();
      bus.i_select = 1'b0;
      check($sformatf("tbl_rd%0d", i), 256'(bus.o_data_rd), 256'(tbl[i].exp));
    end

    // 3. Start blocked by the writer, then a stray start mid-shift.
    run(1'b1, 0, 0, 5'd0, en, nb, done_t, n_done, d);
    check("blocked_enable", 256'(en), 256'(0));
    check("blocked_busy", 256'(nb), 256'(0));
    check("blocked_done", 256'(n_done), 256'(0));
    run(1'b0, 50, 0, 5'd0, en, nb, done_t, n_done, d);
    check_good_run(en, nb, done_t, n_done);
    check("chain_restored2", 256'(chain), 256'(orig));

    // 4. Reset during SHIFT cycle 80 leaves the chain rotated by 80.
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int t = 1; t < 80; t++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_scanclkena", 256'(scanclkena), 256'(0));
    check("abort_busy", 256'(bus.o_busy), 256'(0));
    check("abort_valid", 256'(bus.o_valid), 256'(0));
    for (int i = 0; i < L; i++) rot[i] = orig[(i + 80) % L];
    check("chain_rotated", 256'(chain), 256'(rot));
    read_byte(5'd5, d);
    check("abort_snap_cleared", 256'(d), 256'(0));

    // 5. Read during a second shift returns the old snapshot.
    load_chain(byte_pattern(8'h10, 1'b0));
    run(1'b0, 0, 0, 5'd0, en, nb, done_t, n_done, d);
    check_good_run(en, nb, done_t, n_done);
    load_chain(byte_pattern(8'hA5, 1'b1));
    run(1'b0, 0, 10, 5'd0, en, nb, done_t, n_done, d);
    check("read_during_shift", 256'(d), 256'(8'h10));
    check_good_run(en, nb, done_t, n_done);
    read_byte(5'd0, d);
    check("read_new", 256'(d), 256'(8'hA5));
    read_byte(5'd25, d);
    check("read_oob", 256'(d), 256'(0));
    exp_img = byte_pattern(8'hA5, 1'b1);

    // Randomized images, random writer-busy blocking, random reads.
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < L; i++) orig[i] = 1'($urandom_range(0, 1));
      load_chain(orig);
      blocked = ($urandom_range(0, 3) == 0);
      run(blocked, 0, 0, 5'd0, en, nb, done_t, n_done, d);
      if (blocked) begin
        check("rnd_blocked_enable", 256'(en), 256'(0));
        check("rnd_blocked_done", 256'(n_done), 256'(0));
      end else begin
        check_good_run(en, nb, done_t, n_done);
        exp_img = orig;
      end
      check("rnd_chain", 256'(chain), 256'(orig));
      for (int r = 0; r < 8; r++) begin
        a = 5'($urandom_range(0, 31));
        read_byte(a, d);
        check($sformatf("rnd_read_a%0d", a), 256'(d), 256'(ref_byte(exp_img, int'(a))));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end
endmodule
